lifo_stack: RTL and testbench

Parametrised synchronous LIFO (stack), successor to the fixed 8-deep × 4-bit LIFO built from DFF shift-register cells.
- Generalised in data width and depth.
- Adds simultaneous push/pop (replace-top), registered pop data with a valid strobe, occupancy count, and sticky overflow/underflow error flags.
- Used as the storage element wherever the design needs last-in-first-out buffering of small words.

---
 rtl/lifo_stack_if.sv | 29 ++
 rtl/lifo_stack.sv | 98 +++++++++
 tb/tb_lifo_stack.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lifo_stack_if.sv
// Handshake and status bundle for lifo_stack.
// The master drives push/pop/din/clr_err; the stack (slave) drives data and status back.
interface lifo_stack_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output push, pop, din, clr_err,
        input  dout, dout_valid, count, empty, full, ovf, unf
    );

    modport slave (
        input  push, pop, din, clr_err,
        output dout, dout_valid, count, empty, full, ovf, unf
    );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO with replace-top on simultaneous push/pop,
// registered pop data with valid strobe, occupancy count and sticky error flags.
module lifo_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    lifo_stack_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    // NOTE: storage is deliberately left out of reset; only control state is reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_replace;
    logic             w_bypass;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;

    // Exact compare against DEPTH so non-power-of-two depths fill correctly.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));

    assign w_do_push = bus.push & ~bus.pop & ~w_full;
    assign w_do_pop  = bus.pop  & ~bus.push & ~w_empty;
    assign w_replace = bus.push &  bus.pop  & ~w_empty;
    assign w_bypass  = bus.push &  bus.pop  &  w_empty;

    assign w_top_idx = AW'(r_count - CW'(1));
    assign w_wr_en   = w_do_push | w_replace;
    assign w_wr_idx  = w_replace ? w_top_idx : AW'(r_count);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= bus.din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the replace-top
    // read of r_mem sees the old value while the same edge writes the new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else begin
            r_dout_valid <= w_do_pop | w_replace | w_bypass;

            if (w_do_pop || w_replace) begin
                r_dout <= r_mem[w_top_idx];
            end else if (w_bypass) begin
                r_dout <= bus.din;
            end

            if (w_do_push) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop) begin
                r_count <= r_count - CW'(1);
            end

            // A new error event in the same cycle as clr_err wins.
            if (bus.push && !bus.pop && w_full) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_err) begin
                r_ovf <= 1'b0;
            end

            if (bus.pop && !bus.push && w_empty) begin
                r_unf <= 1'b1;
            end else if (bus.clr_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.count      = r_count;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.ovf        = r_ovf;
    assign bus.unf        = r_unf;
endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack: an 8x4 instance and a 5x8 instance
// driven with hand-computed vectors covering fill, drain, replace-top, bypass, flags and reset.
module tb_lifo_stack;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    lifo_stack_if #(.WIDTH(4), .DEPTH(8)) ifa ();
    lifo_stack_if #(.WIDTH(8), .DEPTH(5)) ifb ();

    lifo_stack #(.WIDTH(4), .DEPTH(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    lifo_stack #(.WIDTH(8), .DEPTH(5)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.push = 1'b0; ifa.pop = 1'b0; ifa.din = '0; ifa.clr_err = 1'b0;
    endtask

    task automatic idle_b();
        ifb.push = 1'b0; ifb.pop = 1'b0; ifb.din = '0; ifb.clr_err = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_a();
        idle_b();
        rst = 1'b1;
        #3;
        check("rst_count", ifa.count, 0);
        check("rst_empty", ifa.empty, 1);
        check("rst_full",  ifa.full, 0);
        check("rst_dout",  ifa.dout, 0);
        check("rst_valid", ifa.dout_valid, 0);
        check("rst_flags", {ifa.ovf, ifa.unf}, 0);
        #5 rst = 1'b0;

        // 1: fill, then overflow attempt
        for (int i = 1; i <= 8; i++) begin
            ifa.push = 1'b1; ifa.din = 4'(i);
            cyc();
            check("fill_count", ifa.count, i);
            check("fill_full", ifa.full, (i == 8) ? 1 : 0);
            check("fill_valid", ifa.dout_valid, 0);
        end
        check("fill_empty", ifa.empty, 0);
        check("fill_ovf", ifa.ovf, 0);
        ifa.din = 4'h9;
        cyc();
        check("ovf_count", ifa.count, 8);
        check("ovf_set", ifa.ovf, 1);
        idle_a();

        // 2: drain in LIFO order, then underflow attempt
        for (int i = 0; i < 8; i++) begin
            ifa.pop = 1'b1;
            cyc();
            check("drain_dout", ifa.dout, 8 - i);
            check("drain_valid", ifa.dout_valid, 1);
            check("drain_count", ifa.count, 7 - i);
        end
        check("drain_empty", ifa.empty, 1);
        cyc();
        check("unf_set", ifa.unf, 1);
        check("unf_dout_hold", ifa.dout, 1);
        check("unf_valid", ifa.dout_valid, 0);
        check("unf_count", ifa.count, 0);
        idle_a();
        ifa.clr_err = 1'b1;
        cyc();
        check("clr_both", {ifa.ovf, ifa.unf}, 0);
        idle_a();

        // 3: replace-top
        ifa.push = 1'b1; ifa.din = 4'h3; cyc();
        ifa.din = 4'h5; cyc();
        ifa.pop = 1'b1; ifa.din = 4'hA; cyc();
        check("rep_dout", ifa.dout, 5);
        check("rep_valid", ifa.dout_valid, 1);
        check("rep_count", ifa.count, 2);
        idle_a(); ifa.pop = 1'b1; cyc();
        check("rep_pop1", ifa.dout, 4'hA);
        cyc();
        check("rep_pop2", ifa.dout, 3);
        check("rep_empty", ifa.empty, 1);
        idle_a(); cyc();
        check("hold_valid", ifa.dout_valid, 0);
        check("hold_dout", ifa.dout, 3);

        // 4: bypass on empty
        ifa.push = 1'b1; ifa.pop = 1'b1; ifa.din = 4'hC; cyc();
        check("byp_dout", ifa.dout, 4'hC);
        check("byp_valid", ifa.dout_valid, 1);
        check("byp_count", ifa.count, 0);
        check("byp_flags", {ifa.ovf, ifa.unf}, 0);
        idle_a();

        // 5: sticky ovf, clear alone, then set wins over clear
        for (int i = 1; i <= 9; i++) begin
            ifa.push = 1'b1; ifa.din = 4'(i); cyc();
        end
        check("s5_ovf", ifa.ovf, 1);
        idle_a(); ifa.clr_err = 1'b1; cyc();
        check("s5_clr", ifa.ovf, 0);
        ifa.push = 1'b1; ifa.din = 4'hF; cyc();
        check("s5_set_wins", ifa.ovf, 1);
        check("s5_count", ifa.count, 8);
        idle_a();

        // 6: async reset mid-cycle with a push in flight
        rst = 1'b1; #2 rst = 1'b0;
        cyc();
        for (int i = 1; i <= 3; i++) begin
            ifa.push = 1'b1; ifa.din = 4'(i + 4); cyc();
        end
        check("s6_pre_count", ifa.count, 3);
        ifa.pop = 1'b1; cyc();
        ifa.pop = 1'b0;
        check("s6_pre_dout", ifa.dout, 7);
        ifa.clr_err = 1'b0; ifa.push = 1'b0; ifa.pop = 1'b1; cyc();
        ifa.pop = 1'b0; ifa.push = 1'b1; ifa.din = 4'hE;
        check("s6_unf_pre", ifa.unf, 0);
        ifa.push = 1'b1; ifa.pop = 1'b0; ifa.din = 4'hE;
        #2 rst = 1'b1;
        #1;
        check("s6_count", ifa.count, 0);
        check("s6_empty", ifa.empty, 1);
        check("s6_dout", ifa.dout, 0);
        check("s6_valid", ifa.dout_valid, 0);
        check("s6_flags", {ifa.ovf, ifa.unf}, 0);
        cyc();
        check("s6_held", ifa.count, 0);
        idle_a();
        #2 rst = 1'b0;
        ifa.push = 1'b1; ifa.din = 4'h7; cyc();
        check("s6_push_count", ifa.count, 1);
        idle_a(); ifa.pop = 1'b1; cyc();
        check("s6_pop_dout", ifa.dout, 7);
        check("s6_pop_empty", ifa.empty, 1);
        idle_a();

        // 7: 8-bit x 5-deep instance, fill/overflow/drain/underflow
        for (int i = 1; i <= 5; i++) begin
            ifb.push = 1'b1; ifb.din = 8'(8'h10 * i + 1); cyc();
            check("b_fill_count", ifb.count, i);
            check("b_fill_full", ifb.full, (i == 5) ? 1 : 0);
        end
        ifb.din = 8'hEE; cyc();
        check("b_ovf", ifb.ovf, 1);
        check("b_ovf_count", ifb.count, 5);
        idle_b();
        for (int i = 5; i >= 1; i--) begin
            ifb.pop = 1'b1; cyc();
            check("b_drain_dout", ifb.dout, 8'h10 * i + 1);
            check("b_drain_valid", ifb.dout_valid, 1);
            check("b_drain_count", ifb.count, i - 1);
        end
        check("b_empty", ifb.empty, 1);
        cyc();
        check("b_unf", ifb.unf, 1);
        check("b_unf_dout", ifb.dout, 8'h11);
        check("b_unf_valid", ifb.dout_valid, 0);
        idle_b();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
